// File: rtl/button_conditioner_if.sv
// Raw-input / conditioned-output bundle for button_conditioner.
interface button_conditioner_if #(parameter int N = 6);
  logic [N-1:0] raw_in;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] press;

  modport master (output raw_in, input level, rise, fall, press);
  modport slave  (input raw_in, output level, rise, fall, press);
endinterface

// File: rtl/button_conditioner.sv
// Per-channel polarity normalise, 2-flop sync and debounce FSM with rise/fall/press strobes.
// Optional auto-repeat on press: define BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner_ch #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_PERIOD   = 1000
) (
  input  logic clk,
  input  logic preset,
  input  logic s,
  output logic level,
  output logic rise,
  output logic fall,
  output logic press
);
  typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, rise_d, fall_d, press_d;

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      press   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
      press   <= press_d;
    end
  end

  // Counter is compared before increment and cleared on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE: if (s) begin
        state_d = ARMING;
        cnt_d   = '0;
      end
      ARMING: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: if (!s) begin
        state_d = RELEASING;
        cnt_d   = '0;
      end
      RELEASING: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          rphase_q, rphase_d;  // 0: waiting initial delay, 1: periodic
  logic          rep_hit;

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rphase_q <= rphase_d;
    end
  end

  always_comb begin
    rcnt_d   = rcnt_q;
    rphase_d = rphase_q;
    rep_hit  = 1'b0;
    if (rise_d || state_d == IDLE) begin
      rcnt_d   = '0;
      rphase_d = 1'b0;
    end else if (state_q == HELD || state_q == RELEASING) begin
      if (rcnt_q == (rphase_q ? R_PERIOD : R_DELAY)) begin
        rep_hit  = 1'b1;
        rcnt_d   = '0;
        rphase_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
    press_d = rise_d | rep_hit;
  end
`else
  assign press_d = rise_d;
`endif
endmodule

module button_conditioner #(
  parameter int             N               = 6,
  parameter logic [N-1:0]   ACTIVE_LOW_MASK = 6'b001111,
  parameter int             DEBOUNCE_CYCLES = 16,
  parameter int             CNT_W           = 16,
  parameter int             REPEAT_DELAY    = 5000,
  parameter int             REPEAT_PERIOD   = 1000
) (
  input logic                 clk,
  input logic                 preset,
  button_conditioner_if.slave bus
);
  logic [N-1:0] sync1, sync2;
  logic [N-1:0] level_w, rise_w, fall_w, press_w;

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.raw_in ^ ACTIVE_LOW_MASK;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_conditioner_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk    (clk),
      .preset (preset),
      .s      (sync2[i]),
      .level  (level_w[i]),
      .rise   (rise_w[i]),
      .fall   (fall_w[i]),
      .press  (press_w[i])
    );
  end

  assign bus.level = level_w;
  assign bus.rise  = rise_w;
  assign bus.fall  = fall_w;
  assign bus.press = press_w;
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Per-channel input conditioner for the extension-board push buttons and DIP switches. Each raw asynchronous input is polarity-normalised, two-flop synchronised and debounced by a per-channel state machine. The block produces a clean level plus single-cycle rise, fall and press strobes. It sits directly upstream of the flip-flop exercise logic, which consumes the clean levels as data and enables, and the strobes as clock-enables in place of raw button edges.

## Interface
Parameters:
- N, 6: number of channels (button_mb[3:0], button_2, button_1).
- ACTIVE_LOW_MASK, 6'b001111: bit i set means channel i is active-low and is inverted before synchronisation.
- DEBOUNCE_CYCLES, 16: stable cycles required to accept a change; legal range ≥ 2.
- CNT_W, 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 5000: cycles in HELD before the first auto-repeat (macro only).
- REPEAT_PERIOD, 1000: cycles between auto-repeats (macro only).

Ports:
- clk  in  1  system clock.
- preset  in  1  reset; asynchronous, active-high.
- raw_in  in  N  unsynchronised button/switch inputs.
- level  out  N  debounced, active-high level.
- rise  out  N  one-cycle strobe on an accepted inactive→active change.
- fall  out  N  one-cycle strobe on an accepted active→inactive change.
- press  out  N  one-cycle strobe on rise, plus auto-repeats when enabled.

Reset preset, asynchronous, active-high; clock clk.

## Operation
- Normalise: n[i] = raw_in[i] ^ ACTIVE_LOW_MASK[i]. Synchronise through sync1 then sync2; s[i] = sync2[i].
- Channels are fully independent. Each has a state and a CNT_W-bit counter cnt.
- IDLE (level 0): if s = 1, go to ARMING with cnt = 0.
- ARMING (level 0): if s = 0, return to IDLE with cnt = 0. Otherwise, if cnt == DEBOUNCE_CYCLES-1, go to HELD, set level = 1 and pulse rise and press. Otherwise cnt++.
- HELD (level 1): if s = 0, go to RELEASING with cnt = 0.
- RELEASING (level 1): if s = 1, return to HELD. Otherwise, if cnt == DEBOUNCE_CYCLES-1, go to IDLE, set level = 0 and pulse fall. Otherwise cnt++.
- Bounce: any opposite sample in ARMING or RELEASING aborts the transition and restarts the count. Pulses shorter than DEBOUNCE_CYCLES+1 synchronised cycles produce no output.
- Counter never wraps; it is compared before incrementing and cleared on every state entry.
- Strobes are registered and high for exactly one cycle. rise and fall on the same channel are never high together.

## Timing
- Reset values: sync1, sync2, level, rise, fall and press are 0; all states are IDLE; all counters are 0. Assertion takes effect immediately, without a clock.
- Reset deassertion mid-bounce: channels restart from IDLE. A button already held is accepted after the normal latency; no strobe is lost or duplicated.
- Press latency: if raw is active and steady from clock edge E1, rise, press and level go high after edge E1+2+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+3 edges (19 at default).
- Release latency is identical: fall goes high and level goes low after edge E1+2+DEBOUNCE_CYCLES.
- Simultaneous activity on several channels produces strobes on the same cycle where timing coincides.

## Configuration
- BUTTON_CONDITIONER_AUTOREPEAT_EN defined: each channel gets a repeat counter, cleared on entry to HELD.
  - press pulses once when the channel has been in HELD or RELEASING for REPEAT_DELAY cycles.
  - After that, press pulses every REPEAT_PERIOD cycles while the channel stays in HELD or RELEASING.
  - The repeat counter is reset on return to IDLE.
  - rise and fall are unaffected.
- Undefined: no repeat logic is synthesised, and press is identical to rise.

## Test plan
- Reset: assert preset mid-simulation with raw_in = 6'b001111 (all inactive) → all outputs 0 immediately; no strobe after release.
- Clean press on channel 4 (active-high) held 40 cycles → rise[4] and press[4] high for one cycle after edge 19, level[4] = 1. After release, fall[4] pulses 19 edges later.
- Bounce: toggle raw_in[0] low/high every 5 cycles for 60 cycles, then hold low (active) → no strobe during bouncing; exactly one rise[0] 19 edges after the final transition.
- Glitch: raw_in[5] active for 10 cycles only → level[5] stays 0; rise and fall stay 0.
- Simultaneous: press channels 1 and 4 on the same edge → both rise bits high in the same cycle; other channels stay 0.
- Macro on (REPEAT_DELAY = 50, REPEAT_PERIOD = 20), hold channel 2 for 120 cycles after acceptance → press[2] pulses at acceptance and at +50, +70, +90 and +110; rise[2] pulses only once.
